// File: rtl/fetch_aligner.sv
// Fetch aligner: pulls word-aligned 32-bit words from instruction memory and
// realigns the mixed 16/32-bit instruction stream into one raw instruction per
// decode handshake, with its PC and a compressed flag.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   redirect_i/_pc_i       flush the buffer and restart fetch at a halfword PC
//   imem_req_o/_addr_o     word fetch request and word address
//   imem_ack_i/_rdata_i    request accepted; read data valid in the same cycle
//   instr_o/_pc_o          raw instruction ({16'b0, half} when compressed) and PC
//   instr_compressed_o     instruction is 16-bit
//   instr_valid_o/ready_i  decode handshake
module fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_compressed_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i
);

  localparam int unsigned HalfW = 16;
  localparam int unsigned CntW  = 2;

  localparam logic [31:0] HalfMask = 32'hFFFF_FFFE;
  localparam logic [31:0] WordMask = 32'hFFFF_FFFC;

  // Three-entry halfword buffer, h0 is the oldest halfword.
  logic [HalfW-1:0] h0Q, h1Q, h2Q;
  logic [HalfW-1:0] h0D, h1D, h2D;
  logic [CntW-1:0]  cntQ, cntD;
  logic [31:0]      pcQ, pcD;
  logic [31:0]      fetchAddrQ, fetchAddrD;
  logic             skipQ, skipD;

  logic             compressedC;
  logic             availC;
  logic             fireC;
  logic             pushEnC;
  logic [CntW-1:0]  popCntC;
  logic [CntW-1:0]  pushCntC;
  logic [CntW-1:0]  remainC;
  logic [HalfW-1:0] pushLoC, pushHiC;
  logic [HalfW-1:0] sh0C, sh1C, sh2C;

  // Handshake and output view of the buffer head.
  always_comb begin
    compressedC        = (h0Q[1:0] != 2'b11);
    availC             = ((cntQ >= 2'd1) && compressedC) || (cntQ >= 2'd2);
    instr_valid_o      = availC & ~redirect_i;
    instr_o            = compressedC ? {16'b0, h0Q} : {h1Q, h0Q};
    instr_pc_o         = pcQ;
    instr_compressed_o = compressedC;
    imem_req_o         = (cntQ <= 2'd1);
    imem_addr_o        = fetchAddrQ;
  end

  // Next-state: pop from the head, then append fetched halves behind what is left.
  always_comb begin
    fireC    = instr_valid_o & instr_ready_i;
    pushEnC  = imem_req_o & imem_ack_i & ~redirect_i;
    popCntC  = fireC ? (compressedC ? 2'd1 : 2'd2) : 2'd0;
    pushCntC = pushEnC ? (skipQ ? 2'd1 : 2'd2) : 2'd0;
    remainC  = cntQ - popCntC;

    // A halfword-aligned target skips the low half of its first word.
    pushLoC  = skipQ ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
    pushHiC  = imem_rdata_i[31:16];

    sh0C = h0Q;
    sh1C = h1Q;
    sh2C = h2Q;
    case (popCntC)
      2'd1: begin
        sh0C = h1Q;
        sh1C = h2Q;
        sh2C = '0;
      end
      2'd2: begin
        sh0C = h2Q;
        sh1C = '0;
        sh2C = '0;
      end
      default: ;
    endcase

    h0D = sh0C;
    h1D = sh1C;
    h2D = sh2C;
    // Pushes only happen when count <= 1, so at most one halfword remains.
    if (pushEnC) begin
      case (remainC)
        2'd0: begin
          h0D = pushLoC;
          if (pushCntC == 2'd2) h1D = pushHiC;
        end
        2'd1: begin
          h1D = pushLoC;
          if (pushCntC == 2'd2) h2D = pushHiC;
        end
        default: ;
      endcase
    end

    cntD       = remainC + pushCntC;
    pcD        = pcQ;
    fetchAddrD = fetchAddrQ;
    skipD      = skipQ;

    if (fireC) pcD = pcQ + (compressedC ? 32'd2 : 32'd4);
    if (pushEnC) begin
      fetchAddrD = fetchAddrQ + 32'd4;
      skipD      = 1'b0;
    end

    // Redirect wins over same-cycle ack and consume.
    if (redirect_i) begin
      cntD       = '0;
      pcD        = redirect_pc_i & HalfMask;
      fetchAddrD = redirect_pc_i & WordMask;
      skipD      = redirect_pc_i[1];
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h0Q        <= '0;
      h1Q        <= '0;
      h2Q        <= '0;
      cntQ       <= '0;
      pcQ        <= RESET_PC & HalfMask;
      fetchAddrQ <= RESET_PC & WordMask;
      skipQ      <= RESET_PC[1];
    end else begin
      h0Q        <= h0D;
      h1Q        <= h1D;
      h2Q        <= h2D;
      cntQ       <= cntD;
      pcQ        <= pcD;
      fetchAddrQ <= fetchAddrD;
      skipQ      <= skipD;
    end
  end

endmodule
